// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame controller.
// Holds the FSM state encoding, the serial line levels and the counter sizing rule.
package uart_tx_pkg;

    localparam int DATA_WIDTH = 8;

    // A one-bit word still needs a one-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_WIDTH = cnt_width(DATA_WIDTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_START  = START,
        ST_DATA   = DATA,
        ST_PARITY = PARITY,
        ST_STOP   = STOP
    } tx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register and bit counter for one UART data word.
// Loads the word at accept, shifts right once per data bit, and flags the last bit.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             head_bit,
    output logic             next_bit,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0] shift_r;
    logic [CNT_W-1:0] count_r;

    // Word storage and bit position; the counter holds on the last bit so it never wraps.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            shift_r <= {WIDTH{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            shift_r <= data;
            count_r <= {CNT_W{1'b0}};
        end else if (shift) begin
            shift_r <= {1'b0, shift_r[WIDTH-1:1]};
            if (!done) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end else begin
            shift_r <= shift_r;
            count_r <= count_r;
        end
    end

    assign head_bit = shift_r[0];
    assign next_bit = shift_r[1];
    assign done     = (count_r == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: start, WIDTH data bits LSB first, optional parity, stop.
// Line and Busy are registered from the next state so they line up with the current state.
module uart_tx_fsm
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             Data_Valid,
    input  logic             PAR_EN,
    input  logic             parity,
    output logic             TX_OUT,
    output logic             Busy
);

    tx_state_e state_r;
    tx_state_e state_next_s;
    logic      tx_out_r;
    logic      busy_r;
    logic      par_en_r;
    logic      tx_next_s;
    logic      busy_next_s;
    logic      load_s;
    logic      shift_s;
    logic      head_bit_s;
    logic      next_bit_s;
    logic      done_s;

    uart_tx_serializer #(
        .WIDTH(WIDTH)
    ) u_serializer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load_s),
        .shift    (shift_s),
        .data     (P_DATA),
        .head_bit (head_bit_s),
        .next_bit (next_bit_s),
        .done     (done_s)
    );

    // Next-state logic; a new word is accepted only from IDLE, so Data_Valid while busy is dropped.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Data_Valid) begin
                    load_s       = 1'b1;
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_next_s = ST_DATA;
            end
            ST_DATA: begin
                shift_s = 1'b1;
                if (done_s) begin
                    if (par_en_r) begin
                        state_next_s = ST_PARITY;
                    end else begin
                        state_next_s = ST_STOP;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                state_next_s = ST_STOP;
            end
            ST_STOP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the coming state; parity is only reachable from DATA, so it is sampled exactly once.
    always_comb begin
        tx_next_s = IDLE_LEVEL;
        case (state_next_s)
            ST_IDLE: begin
                tx_next_s = IDLE_LEVEL;
            end
            ST_START: begin
                tx_next_s = START_BIT;
            end
            ST_DATA: begin
                if (state_r == ST_DATA) begin
                    tx_next_s = next_bit_s;
                end else begin
                    tx_next_s = head_bit_s;
                end
            end
            ST_PARITY: begin
                tx_next_s = parity;
            end
            ST_STOP: begin
                tx_next_s = STOP_BIT;
            end
            default: begin
                tx_next_s = IDLE_LEVEL;
            end
        endcase
        busy_next_s = (state_next_s != ST_IDLE);
    end

    // State, registered outputs and the per-frame parity enable.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r  <= ST_IDLE;
            tx_out_r <= IDLE_LEVEL;
            busy_r   <= 1'b0;
            par_en_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            tx_out_r <= tx_next_s;
            busy_r   <= busy_next_s;
            if (load_s) begin
                par_en_r <= PAR_EN;
            end else begin
                par_en_r <= par_en_r;
            end
        end
    end

    assign TX_OUT = tx_out_r;
    assign Busy   = busy_r;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Scoreboard bench for uart_tx_fsm: stimulus queues hand-computed frames,
// a monitor captures each Busy-high window and compares it against the queue.
module tb_uart_tx_fsm;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       parity;
    logic       TX_OUT;
    logic       Busy;

    typedef struct {
        logic [15:0] bits;
        int          len;
        int          gap;
        string       name;
    } frame_t;

    frame_t exp_q[$];
    bit     mon_en    = 1'b0;
    bit     stim_done = 1'b0;
    int     n_checks  = 0;
    int     n_fails   = 0;

    uart_tx_fsm #(.WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .parity     (parity),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic frame_t mk(input logic [15:0] bits, input int len, input int gap, input string name);
        frame_t f;
        f.bits = bits;
        f.len  = len;
        f.gap  = gap;
        f.name = name;
        return f;
    endfunction

    task automatic pulse(input logic [7:0] d, input logic pe);
        P_DATA     = d;
        PAR_EN     = pe;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    // Stimulus: every expected frame is serial bit order {stop, [parity], data, start}, bit 0 sent first.
    initial begin
        RST        = 1'b0;
        Data_Valid = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        parity     = 1'b0;
        repeat (3) @(negedge CLK);
        mon_en = 1'b1;
        RST    = 1'b1;
        repeat (5) @(negedge CLK);

        exp_q.push_back(mk(16'({1'b1, 8'hA5, 1'b0}), 10, -1, "a5_nopar"));
        pulse(8'hA5, 1'b0);
        repeat (14) @(negedge CLK);

        parity = 1'b0;
        exp_q.push_back(mk(16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, -1, "a5_par0"));
        pulse(8'hA5, 1'b1);
        repeat (14) @(negedge CLK);

        parity = 1'b1;
        exp_q.push_back(mk(16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, -1, "a5_par1"));
        pulse(8'hA5, 1'b1);
        repeat (14) @(negedge CLK);

        parity = 1'b0;
        exp_q.push_back(mk(16'({1'b1, 8'hFF, 1'b0}), 10, -1, "ff_ignore_3c"));
        pulse(8'hFF, 1'b0);
        repeat (3) @(negedge CLK);
        P_DATA     = 8'h3C;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (14) @(negedge CLK);

        exp_q.push_back(mk(16'({1'b1, 8'h01, 1'b0}), 10, -1, "b2b_01"));
        exp_q.push_back(mk(16'({1'b1, 8'h80, 1'b0}), 10, 1, "b2b_80"));
        P_DATA     = 8'h01;
        PAR_EN     = 1'b0;
        Data_Valid = 1'b1;
        @(negedge CLK);
        P_DATA = 8'h80;
        repeat (11) @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (14) @(negedge CLK);

        // Reset sampled at the end of cycle 5: only start and data bits 0..3 of 0x0F get out.
        exp_q.push_back(mk(16'h001E, 5, -1, "abort_0f"));
        pulse(8'h0F, 1'b0);
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);

        parity = 1'b1;
        exp_q.push_back(mk(16'({1'b1, 1'b1, 8'hC3, 1'b0}), 11, -1, "c3_after_reset"));
        pulse(8'hC3, 1'b1);
        repeat (16) @(negedge CLK);
        stim_done = 1'b1;
    end

    // Monitor: idle-level checks every idle cycle, frame capture while Busy, end-of-run scoreboard checks.
    initial begin
        logic [15:0] cap_bits;
        logic [15:0] mask;
        int          cap_len;
        int          gap;
        int          cap_gap;
        int          frames_seen;
        int          cycles;
        bit          in_frame;
        frame_t      e;
        cap_bits    = 16'h0000;
        cap_len     = 0;
        gap         = 0;
        cap_gap     = 0;
        frames_seen = 0;
        cycles      = 0;
        in_frame    = 1'b0;
        forever begin
            @(negedge CLK);
            cycles++;
            if (cycles > 3000) begin
                n_checks++;
                n_fails++;
                $display("FAIL timeout: cycles %0d exceeded limit 3000", cycles);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
                $finish;
            end
            if (stim_done) begin
                n_checks++;
                if (exp_q.size() != 0) begin
                    n_fails++;
                    $display("FAIL frames_pending: %0d expected frames never seen, required 0", exp_q.size());
                end
                n_checks++;
                if (frames_seen != 8) begin
                    n_fails++;
                    $display("FAIL frame_count: got %0d frames, expected 8", frames_seen);
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
                $finish;
            end
            if (mon_en) begin
                if (Busy === 1'b1) begin
                    if (!in_frame) begin
                        in_frame = 1'b1;
                        cap_len  = 0;
                        cap_bits = 16'h0000;
                        cap_gap  = gap;
                        gap      = 0;
                    end
                    if (cap_len < 16) begin
                        cap_bits[cap_len] = TX_OUT;
                    end
                    cap_len++;
                end else begin
                    n_checks++;
                    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                        n_fails++;
                        $display("FAIL idle_level: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0 at cycle %0d",
                                 TX_OUT, Busy, cycles);
                    end
                    if (in_frame) begin
                        in_frame = 1'b0;
                        frames_seen++;
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fails++;
                            $display("FAIL unexpected_frame: got bits %h len %0d, expected no frame",
                                     cap_bits, cap_len);
                        end else begin
                            e = exp_q.pop_front();
                            if (cap_len != e.len) begin
                                n_fails++;
                                $display("FAIL %s_len: got %0d cycles, expected %0d", e.name, cap_len, e.len);
                            end
                            n_checks++;
                            mask = (16'h0001 << e.len) - 16'h0001;
                            if ((cap_bits & mask) !== (e.bits & mask)) begin
                                n_fails++;
                                $display("FAIL %s_bits: got %h, expected %h", e.name, cap_bits & mask, e.bits & mask);
                            end
                            if (e.gap >= 0) begin
                                n_checks++;
                                if (cap_gap != e.gap) begin
                                    n_fails++;
                                    $display("FAIL %s_gap: got %0d idle cycles, expected %0d", e.name, cap_gap, e.gap);
                                end
                            end
                        end
                        gap = 0;
                    end
                    gap++;
                end
            end
        end
    end

endmodule
